cmos_frame_gate: RTL and testbench
==================================

Name: cmos_frame_gate

Overview:
Sequencer between the CMOS pixel source and the CSI-2 TX bridge input (fv/lv/dvalid/pixdata). It holds the bridge input idle until the D-PHY PLL is locked, Tinit has completed and software enables streaming. It then releases traffic only on a clean frame boundary, so the bridge never sees a partial frame. It also drains frames on disable, aborts on PLL loss, and reports frame/line statistics and line-length errors.

Parameters:
DWIDTH, 10, pixel data width (8/10/12/24).
CNT_W, 16, width of pixel, line and frame counters.
SKIP_FRAMES, 0, number of complete frames discarded after arming, before forwarding starts (0..15).
LONG_EVEN_EN, 0, 1 = YUV420 mode: even lines are checked against their own reference length.

Ports:
pix_clk_i  in  1  pixel clock; all logic on rising edge
reset_n_i  in  1  asynchronous active-low reset
pll_lock_i  in  1  D-PHY PLL lock
tinit_done_i  in  1  D-PHY Tinit complete
enable_i  in  1  streaming enable (level)
fv_i  in  1  frame valid from CMOS source
lv_i  in  1  line valid from CMOS source
pixdata_i  in  DWIDTH  pixel data
fv_o  out  1  gated frame valid to bridge
lv_o  out  1  gated line valid to bridge
dvalid_o  out  1  gated data valid (= lv_o)
pixdata_o  out  DWIDTH  registered pixel data
state_o  out  3  current FSM state encoding
frame_cnt_o  out  CNT_W  frames forwarded (wraps)
line_cnt_o  out  CNT_W  lines in last completed frame
pix_cnt_o  out  CNT_W  pixels in last completed line
err_len_o  out  1  sticky line-length mismatch
err_clr_i  in  1  clears err_len_o

Behaviour:
- Reset: all outputs 0; state IDLE; counters and reference lengths 0.
- Input edge detection uses one register stage of fv_i/lv_i. Forwarded outputs are registered: 1-cycle latency from input to output, no pixel dropped or duplicated inside a forwarded frame.
- ready = pll_lock_i & tinit_done_i.
- States and encoding:
  - IDLE (0): wait for ready & enable_i, then go to WAIT_LOW.
  - WAIT_LOW (1): wait for fv_i = 0 (sampled), then go to WAIT_RISE. This guarantees a partial frame in progress is never forwarded.
  - WAIT_RISE (2): on an fv_i rising edge, go to SKIP if the skip counter < SKIP_FRAMES, else to ACTIVE. The first forwarded cycle is the rising-edge cycle, so fv_o rises 1 cycle after fv_i.
  - SKIP (3): on an fv_i falling edge, increment the skip counter and go to WAIT_RISE.
  - ACTIVE (4): fv_o = fv_i, lv_o = dvalid_o = lv_i & fv_i, pixdata_o = pixdata_i.
    - On an fv_i falling edge: increment frame_cnt_o, latch line_cnt_o. Stay in ACTIVE if enable_i = 1, else go to IDLE.
    - enable_i low mid-frame: behave as DRAIN (the current frame completes, then IDLE). There is no separate state; the exit decision is taken at the fv fall.
- Outside ACTIVE, fv_o/lv_o/dvalid_o are 0 and pixdata_o holds 0.
- pll_lock_i or tinit_done_i deasserting in any state: go to IDLE on the next edge and force all gated outputs to 0 on that same edge (abort). frame_cnt_o does not increment for an aborted frame. The skip counter resets on every entry to IDLE.
- Counting (ACTIVE only):
  - Pixel counter increments on each lv_o cycle and saturates at all-ones. On an lv falling edge it is latched to pix_cnt_o and cleared.
  - Line counter increments on each lv fall, clears at fv rise, and saturates.
- Line-length check:
  - The first line of a frame sets ref_odd. With LONG_EVEN_EN = 1, the second line sets ref_even.
  - Each later line is compared with ref_odd, or with ref_even for even line index when LONG_EVEN_EN = 1. A mismatch sets err_len_o.
  - References are re-captured every frame.
- err_len_o priority: err_clr_i clears it, but a mismatch in the same cycle wins and it stays 1.
- lv_i high while fv_i is low: not forwarded and not counted.
- frame_cnt_o wraps from all-ones to 0.

Test Plan:
- Reset release, pll_lock=1, tinit_done=1, enable=1, source idle, then 1 frame of 4 lines x 1000 pixels -> fv_o/lv_o track the inputs with 1-cycle delay, frame_cnt_o=1, line_cnt_o=4, pix_cnt_o=1000 (0x3E8), err_len_o=0.
- enable asserted while fv_i is high in line 2 of a frame -> that frame is fully suppressed (fv_o=0 throughout), the next frame is forwarded complete, frame_cnt_o=1.
- SKIP_FRAMES=2, 3 frames sent -> only the third frame appears on fv_o, frame_cnt_o=1.
- enable deasserted in line 2 of a 4-line frame -> all 4 lines forwarded, then state_o=0 and the next frame is blocked, frame_cnt_o incremented by 1.
- pll_lock_i dropped mid-line -> fv_o/lv_o are 0 on the next edge, state_o=0, frame_cnt_o unchanged. After relock the bench sees the WAIT_LOW sequence again.
- Line 3 of 1000 pixels shortened to 998 with LONG_EVEN_EN=0 -> err_len_o=1, held until err_clr_i. With LONG_EVEN_EN=1 and alternating 1000/2000-pixel lines -> err_len_o stays 0.

Source files
------------

// File: rtl/cmos_frame_gate.sv
// Frame-boundary gate between the CMOS pixel source and the CSI-2 TX bridge.
// Forwards only whole frames once the D-PHY is ready and streaming is enabled.
module cmos_frame_gate #(
    parameter int DWIDTH       = 10,
    parameter int CNT_W        = 16,
    parameter int SKIP_FRAMES  = 0,
    parameter int LONG_EVEN_EN = 0
) (
    input  logic              pix_clk_i,
    input  logic              reset_n_i,
    input  logic              pll_lock_i,
    input  logic              tinit_done_i,
    input  logic              enable_i,
    input  logic              fv_i,
    input  logic              lv_i,
    input  logic [DWIDTH-1:0] pixdata_i,
    output logic              fv_o,
    output logic              lv_o,
    output logic              dvalid_o,
    output logic [DWIDTH-1:0] pixdata_o,
    output logic [2:0]        state_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic [CNT_W-1:0]  line_cnt_o,
    output logic [CNT_W-1:0]  pix_cnt_o,
    output logic              err_len_o,
    input  logic              err_clr_i
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOW  = 3'd1,
        WAIT_RISE = 3'd2,
        SKIP      = 3'd3,
        ACTIVE    = 3'd4
    } state_t;

    localparam logic [3:0]       SKIP_N  = 4'(SKIP_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             fv_q;
    logic [3:0]       skip_cnt;
    logic [CNT_W-1:0] pix_acc;
    logic [CNT_W-1:0] line_acc;
    logic [CNT_W-1:0] ref_odd;
    logic [CNT_W-1:0] ref_even;

    logic             ready;
    logic             fv_rise;
    logic             fv_fall;
    logic             start;
    logic             fwd;
    logic             lv_g;
    logic             lv_fall;
    logic             frame_end;
    logic             mismatch;
    logic [CNT_W-1:0] pix_inc;
    logic [CNT_W-1:0] line_inc;
    logic [CNT_W-1:0] line_next;
    logic [CNT_W-1:0] ref_sel;

    assign ready   = pll_lock_i & tinit_done_i;
    assign fv_rise = fv_i & ~fv_q;
    assign fv_fall = ~fv_i & fv_q;
    assign start   = (state == WAIT_RISE) & fv_rise & (skip_cnt >= SKIP_N);
    assign fwd     = ready & ((state == ACTIVE) | start);
    assign lv_g    = lv_i & fv_i;
    // lv_o is the previous forwarded line-valid, so it doubles as the edge register
    assign lv_fall = fwd & lv_o & ~lv_g;
    assign frame_end = ready & (state == ACTIVE) & fv_fall;

    assign pix_inc   = (pix_acc == CNT_MAX) ? pix_acc : pix_acc + 1'b1;
    assign line_inc  = (line_acc == CNT_MAX) ? line_acc : line_acc + 1'b1;
    assign line_next = lv_fall ? line_inc : line_acc;

    // line_acc odd means the line just ending has an even index
    assign ref_sel  = ((LONG_EVEN_EN != 0) && line_acc[0]) ? ref_even : ref_odd;
    assign mismatch = lv_fall && (line_acc != '0)
                   && !((LONG_EVEN_EN != 0) && (line_acc == 1))
                   && (pix_acc != ref_sel);

    assign state_o = state;

    always_comb begin
        state_nxt = state;
        if (!ready) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable_i) state_nxt = WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!enable_i)  state_nxt = IDLE;
                    else if (!fv_i) state_nxt = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (!enable_i)   state_nxt = IDLE;
                    else if (fv_rise)
                        state_nxt = (skip_cnt < SKIP_N) ? SKIP : ACTIVE;
                end
                SKIP: begin
                    if (!enable_i)    state_nxt = IDLE;
                    else if (fv_fall) state_nxt = WAIT_RISE;
                end
                ACTIVE: begin
                    if (!enable_i && !fv_i) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge pix_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            fv_q        <= 1'b0;
            skip_cnt    <= '0;
            fv_o        <= 1'b0;
            lv_o        <= 1'b0;
            dvalid_o    <= 1'b0;
            pixdata_o   <= '0;
            pix_acc     <= '0;
            line_acc    <= '0;
            ref_odd     <= '0;
            ref_even    <= '0;
            frame_cnt_o <= '0;
            line_cnt_o  <= '0;
            pix_cnt_o   <= '0;
            err_len_o   <= 1'b0;
        end else begin
            state     <= state_nxt;
            fv_q      <= fv_i;
            fv_o      <= fwd & fv_i;
            lv_o      <= fwd & lv_g;
            dvalid_o  <= fwd & lv_g;
            pixdata_o <= fwd ? pixdata_i : '0;

            if (state == IDLE)
                skip_cnt <= '0;
            else if (ready && state == SKIP && fv_fall && skip_cnt != 4'hF)
                skip_cnt <= skip_cnt + 1'b1;

            if (!fwd) begin
                pix_acc <= '0;
            end else if (lv_fall) begin
                pix_cnt_o <= pix_acc;
                pix_acc   <= '0;
            end else if (lv_g) begin
                pix_acc <= pix_inc;
            end

            if (!fwd || fv_rise)
                line_acc <= '0;
            else
                line_acc <= line_next;

            if (frame_end) begin
                frame_cnt_o <= frame_cnt_o + 1'b1;
                line_cnt_o  <= line_next;
            end

            if (lv_fall && line_acc == '0)
                ref_odd <= pix_acc;
            else if (lv_fall && LONG_EVEN_EN != 0 && line_acc == 1)
                ref_even <= pix_acc;

            if (mismatch)
                err_len_o <= 1'b1;
            else if (err_clr_i)
                err_len_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmos_frame_gate.sv
// Directed bench for cmos_frame_gate: three instances (default, skip=2,
// YUV420 length check) share the source; each has its own enable.
module tb_cmos_frame_gate;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll = 1'b0;
    logic       tinit = 1'b0;
    logic       fv = 1'b0;
    logic       lv = 1'b0;
    logic       err_clr = 1'b0;
    logic [9:0] pix = '0;
    logic       en [3];

    logic        fvo [3];
    logic        lvo [3];
    logic        dvo [3];
    logic [9:0]  pdo [3];
    logic [2:0]  st  [3];
    logic [15:0] fc  [3];
    logic [15:0] lc  [3];
    logic [15:0] pc  [3];
    logic        er  [3];

    int   errors = 0;
    int   checks = 0;
    int   sel = 0;
    logic exp_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cmos_frame_gate #(
            .DWIDTH(10),
            .CNT_W(16),
            .SKIP_FRAMES(g == 1 ? 2 : 0),
            .LONG_EVEN_EN(g == 2 ? 1 : 0)
        ) dut (
            .pix_clk_i(clk),
            .reset_n_i(rst_n),
            .pll_lock_i(pll),
            .tinit_done_i(tinit),
            .enable_i(en[g]),
            .fv_i(fv),
            .lv_i(lv),
            .pixdata_i(pix),
            .fv_o(fvo[g]),
            .lv_o(lvo[g]),
            .dvalid_o(dvo[g]),
            .pixdata_o(pdo[g]),
            .state_o(st[g]),
            .frame_cnt_o(fc[g]),
            .line_cnt_o(lc[g]),
            .pix_cnt_o(pc[g]),
            .err_len_o(er[g]),
            .err_clr_i(err_clr)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one source cycle; forwarded bundle must equal the inputs when exp_on
    task automatic cyc(input logic f, input logic l);
        logic [12:0] exp;
        fv  = f;
        lv  = l;
        pix = pix + 10'd1;
        step();
        exp = exp_on ? {f, f & l, f & l, pix} : 13'd0;
        chk("fwd", {19'd0, fvo[sel], lvo[sel], dvo[sel], pdo[sel]},
            {19'd0, exp});
    endtask

    task automatic ln(input int n);
        repeat (n) cyc(1'b1, 1'b1);
        repeat (2) cyc(1'b1, 1'b0);
    endtask

    task automatic frame(input int a, input int b, input int c, input int d);
        repeat (2) cyc(1'b1, 1'b0);
        ln(a);
        ln(b);
        ln(c);
        ln(d);
        repeat (3) cyc(1'b0, 1'b0);
    endtask

    initial begin
        en[0] = 1'b0;
        en[1] = 1'b0;
        en[2] = 1'b0;

        // reset
        step();
        chk("rst_out", {19'd0, fvo[0], lvo[0], dvo[0], pdo[0]}, 0);
        chk("rst_state", st[0], 0);
        chk("rst_fc", fc[0], 0);
        chk("rst_lc", lc[0], 0);
        chk("rst_pc", pc[0], 0);
        chk("rst_err", er[0], 0);

        // bring-up and one 4x1000 frame
        rst_n = 1'b1;
        pll   = 1'b1;
        tinit = 1'b1;
        en[0] = 1'b1;
        cyc(1'b0, 1'b0);
        chk("st_wait_low", st[0], 1);
        cyc(1'b0, 1'b0);
        chk("st_wait_rise", st[0], 2);
        exp_on = 1'b1;
        frame(1000, 1000, 1000, 1000);
        chk("t1_state", st[0], 4);
        chk("t1_fc", fc[0], 1);
        chk("t1_lc", lc[0], 4);
        chk("t1_pc", pc[0], 16'h3E8);
        chk("t1_err", er[0], 0);

        // lv without fv is neither forwarded nor counted
        repeat (3) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("lv_nofv_pc", pc[0], 1000);

        // enable asserted mid-frame: that frame suppressed
        en[0] = 1'b0;
        cyc(1'b0, 1'b0);
        chk("t2_idle", st[0], 0);
        exp_on = 1'b0;
        repeat (2) cyc(1'b1, 1'b0);
        ln(8);
        repeat (3) cyc(1'b1, 1'b1);
        en[0] = 1'b1;
        repeat (5) cyc(1'b1, 1'b1);
        repeat (2) cyc(1'b1, 1'b0);
        ln(8);
        ln(8);
        chk("t2_wait_low", st[0], 1);
        repeat (3) cyc(1'b0, 1'b0);
        chk("t2_wait_rise", st[0], 2);
        exp_on = 1'b1;
        frame(8, 8, 8, 8);
        chk("t2_fc", fc[0], 2);
        chk("t2_lc", lc[0], 4);
        chk("t2_pc", pc[0], 8);

        // enable dropped in line 2: frame drains, next one blocked
        repeat (2) cyc(1'b1, 1'b0);
        ln(8);
        repeat (4) cyc(1'b1, 1'b1);
        en[0] = 1'b0;
        repeat (4) cyc(1'b1, 1'b1);
        repeat (2) cyc(1'b1, 1'b0);
        ln(8);
        ln(8);
        chk("t3_active", st[0], 4);
        cyc(1'b0, 1'b0);
        chk("t3_idle", st[0], 0);
        chk("t3_fc", fc[0], 3);
        chk("t3_lc", lc[0], 4);
        exp_on = 1'b0;
        repeat (2) cyc(1'b0, 1'b0);
        frame(8, 8, 8, 8);
        chk("t3_blocked_fc", fc[0], 3);

        // PLL loss mid-line aborts the frame
        en[0] = 1'b1;
        repeat (3) cyc(1'b0, 1'b0);
        exp_on = 1'b1;
        repeat (2) cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b1);
        pll    = 1'b0;
        exp_on = 1'b0;
        cyc(1'b1, 1'b1);
        chk("t4_idle", st[0], 0);
        chk("t4_fc", fc[0], 3);
        repeat (4) cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        ln(8);
        repeat (2) cyc(1'b0, 1'b0);
        chk("t4_fc_hold", fc[0], 3);
        pll = 1'b1;
        cyc(1'b0, 1'b0);
        chk("t4_relock_wl", st[0], 1);
        cyc(1'b0, 1'b0);
        chk("t4_relock_wr", st[0], 2);

        // short third line flags a length error
        exp_on = 1'b1;
        frame(1000, 1000, 998, 1000);
        chk("t5_err", er[0], 1);
        chk("t5_fc", fc[0], 4);
        chk("t5_pc", pc[0], 1000);
        repeat (3) cyc(1'b0, 1'b0);
        chk("t5_err_hold", er[0], 1);
        err_clr = 1'b1;
        cyc(1'b0, 1'b0);
        err_clr = 1'b0;
        chk("t5_err_clr", er[0], 0);

        // skip two frames on instance 1
        sel   = 1;
        en[1] = 1'b1;
        exp_on = 1'b0;
        repeat (2) cyc(1'b0, 1'b0);
        chk("t6_wait_rise", st[1], 2);
        frame(8, 8, 8, 8);
        chk("t6_skip1_fc", fc[1], 0);
        frame(8, 8, 8, 8);
        chk("t6_skip2_fc", fc[1], 0);
        exp_on = 1'b1;
        frame(8, 8, 8, 8);
        chk("t6_fc", fc[1], 1);
        chk("t6_lc", lc[1], 4);

        // alternating line lengths: fine in YUV420 mode, error otherwise
        sel   = 2;
        en[2] = 1'b1;
        exp_on = 1'b0;
        repeat (2) cyc(1'b0, 1'b0);
        chk("t7_wait_rise", st[2], 2);
        exp_on = 1'b1;
        frame(1000, 2000, 1000, 2000);
        chk("t7_err_even", er[2], 0);
        chk("t7_pc", pc[2], 2000);
        chk("t7_lc", lc[2], 4);
        chk("t7_fc", fc[2], 1);
        chk("t7_err_plain", er[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
